// File: rtl/rst_seq_gen.sv
// Reset sequencer: synchronises arst release, holds every channel in reset for a
// fixed window, then releases the channels one by one in a fixed, staggered order.
module rst_seq_gen #(
    parameter int param_num_ch         = 4,
    parameter int param_sync_stages    = 2,
    parameter int param_hold_cycles    = 16,
    parameter int param_stagger_cycles = 4
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    sw_rst_req,
    input  logic [param_num_ch-1:0] ch_hold,
    output logic [param_num_ch-1:0] rst_out,
    output logic                    busy,
    output logic                    all_released
);

    localparam int HOLD_W = (param_hold_cycles > 1) ? $clog2(param_hold_cycles) : 1;
    localparam int STAG_W = (param_stagger_cycles > 1) ? $clog2(param_stagger_cycles) : 1;
    localparam int IDX_W  = (param_num_ch > 1) ? $clog2(param_num_ch) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(param_hold_cycles - 1);
    localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(param_stagger_cycles - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(param_num_ch - 1);
    localparam logic [IDX_W-1:0]  IDX_PEN   = IDX_W'((param_num_ch > 1) ? param_num_ch - 2 : 0);

    localparam logic [2:0] ST_ASSERT  = 3'd0;
    localparam logic [2:0] ST_SYNC    = 3'd1;
    localparam logic [2:0] ST_HOLD    = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    logic [2:0]                   state, state_nxt;
    logic [param_sync_stages-1:0] sync_ff;
    logic                         sync_out;
    logic [HOLD_W-1:0]            hold_cnt, hold_nxt;
    logic [STAG_W-1:0]            stag_cnt, stag_nxt;
    logic [IDX_W-1:0]             ch_idx, idx_nxt;
    logic [param_num_ch-1:0]      seq_rst, seq_nxt;
    logic                         sw_accept;

    assign sync_out  = sync_ff[param_sync_stages-1];
    assign sw_accept = sw_rst_req &&
                       ((state == ST_HOLD) || (state == ST_RELEASE) || (state == ST_DONE));

    // seq_rst is a thermometer code: channels release LSB first, so each release
    // is a left shift that pulls in one more zero.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        stag_nxt  = stag_cnt;
        idx_nxt   = ch_idx;
        seq_nxt   = seq_rst;

        case (state)
            ST_ASSERT: begin
                state_nxt = ST_SYNC;
            end
            ST_SYNC: begin
                // The last synchroniser stage drops on this edge when its feeder is already low.
                if (!sync_ff[param_sync_stages-2]) begin
                    state_nxt = ST_HOLD;
                    hold_nxt  = '0;
                end
            end
            ST_HOLD: begin
                if (!sync_out && (hold_cnt == HOLD_LAST)) begin
                    hold_nxt  = '0;
                    stag_nxt  = '0;
                    idx_nxt   = '0;
                    seq_nxt   = seq_rst << 1;
                    state_nxt = (param_num_ch == 1) ? ST_DONE : ST_RELEASE;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (stag_cnt == STAG_LAST) begin
                    stag_nxt = '0;
                    seq_nxt  = seq_rst << 1;
                    if (ch_idx != IDX_LAST) begin
                        idx_nxt = ch_idx + 1'b1;
                    end
                    if (ch_idx == IDX_PEN) begin
                        state_nxt = ST_DONE;
                    end
                end else begin
                    stag_nxt = stag_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                seq_nxt = '0;
            end
            default: begin
                state_nxt = ST_ASSERT;
                seq_nxt   = '1;
            end
        endcase

        // A software request restarts the whole hold window from scratch.
        if (sw_accept) begin
            state_nxt = ST_HOLD;
            hold_nxt  = '0;
            stag_nxt  = '0;
            idx_nxt   = '0;
            seq_nxt   = '1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state    <= ST_ASSERT;
            sync_ff  <= '1;
            hold_cnt <= '0;
            stag_cnt <= '0;
            ch_idx   <= '0;
            seq_rst  <= '1;
            rst_out  <= '1;
        end else begin
            state    <= state_nxt;
            sync_ff  <= {sync_ff[param_sync_stages-2:0], 1'b0};
            hold_cnt <= hold_nxt;
            stag_cnt <= stag_nxt;
            ch_idx   <= idx_nxt;
            seq_rst  <= seq_nxt;
            rst_out  <= seq_nxt | ch_hold;
        end
    end

    assign busy         = (state != ST_DONE);
    assign all_released = (state == ST_DONE) && (rst_out == '0);

endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: three instances (3, 1 and 32 channels) share arst and
// sw_rst_req and are checked every edge against release-edge arithmetic.
module tb_rst_seq_gen;

    logic        clk = 1'b0;
    logic        arst;
    logic        sw_rst_req;
    logic [31:0] ch_hold_v;

    logic [2:0]  rst_a;
    logic        busy_a, all_a;
    logic [0:0]  rst_b;
    logic        busy_b, all_b;
    logic [31:0] rst_c;
    logic        busy_c, all_c;

    always #5 clk = ~clk;

    rst_seq_gen #(
        .param_num_ch(3), .param_sync_stages(2),
        .param_hold_cycles(4), .param_stagger_cycles(3)
    ) dut_a (
        .clk(clk), .arst(arst), .sw_rst_req(sw_rst_req), .ch_hold(ch_hold_v[2:0]),
        .rst_out(rst_a), .busy(busy_a), .all_released(all_a)
    );

    rst_seq_gen #(
        .param_num_ch(1), .param_sync_stages(2),
        .param_hold_cycles(4), .param_stagger_cycles(1)
    ) dut_b (
        .clk(clk), .arst(arst), .sw_rst_req(sw_rst_req), .ch_hold(ch_hold_v[0:0]),
        .rst_out(rst_b), .busy(busy_b), .all_released(all_b)
    );

    rst_seq_gen #(
        .param_num_ch(32), .param_sync_stages(3),
        .param_hold_cycles(2), .param_stagger_cycles(1)
    ) dut_c (
        .clk(clk), .arst(arst), .sw_rst_req(sw_rst_req), .ch_hold(ch_hold_v),
        .rst_out(rst_c), .busy(busy_c), .all_released(all_c)
    );

    int n_ch [3] = '{3, 1, 32};
    int s_st [3] = '{2, 2, 3};
    int h_cy [3] = '{4, 4, 2};
    int t_st [3] = '{3, 1, 1};

    // Model: channel i of instance k releases on edge anchor+hold+i*stagger,
    // where anchor is the edge that (re)started the hold window.
    int          anchor [3];
    int          edge_no;
    bit          in_arst;
    logic [31:0] hold_at_edge;
    int          compared;
    int          mismatched;

    function automatic logic [31:0] expRst(input int k);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n_ch[k]; i++) begin
            if (in_arst || (edge_no < anchor[k] + h_cy[k] + i * t_st[k]) || hold_at_edge[i])
                v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic expBusy(input int k);
        return in_arst || (edge_no < anchor[k] + h_cy[k] + (n_ch[k] - 1) * t_st[k]);
    endfunction

    task automatic checkOutput(input string tag);
        for (int k = 0; k < 3; k++) begin
            logic [31:0] act_r, exp_r;
            logic        act_b, act_a, exp_b, exp_a;
            case (k)
                0:       begin act_r = {29'd0, rst_a}; act_b = busy_a; act_a = all_a; end
                1:       begin act_r = {31'd0, rst_b}; act_b = busy_b; act_a = all_b; end
                default: begin act_r = rst_c;          act_b = busy_c; act_a = all_c; end
            endcase
            exp_r = expRst(k);
            exp_b = expBusy(k);
            exp_a = !exp_b && (exp_r == 32'd0);
            compared += 3;
            assert (act_r === exp_r) else begin
                mismatched++;
                $error("[TB] FAIL %s dut%0d rst_out edge %0d: observed %h expected %h",
                       tag, k, edge_no, act_r, exp_r);
            end
            assert (act_b === exp_b) else begin
                mismatched++;
                $error("[TB] FAIL %s dut%0d busy edge %0d: observed %b expected %b",
                       tag, k, edge_no, act_b, exp_b);
            end
            assert (act_a === exp_a) else begin
                mismatched++;
                $error("[TB] FAIL %s dut%0d all_released edge %0d: observed %b expected %b",
                       tag, k, edge_no, act_a, exp_a);
            end
        end
    endtask

    task automatic applyStimulus(input logic req, input logic [31:0] hold, input string tag);
        sw_rst_req = req;
        ch_hold_v  = hold;
        @(posedge clk);
        hold_at_edge = hold;
        if (!in_arst) begin
            edge_no++;
            // A request is honoured only once the instance has reached HOLD.
            if (req) begin
                for (int k = 0; k < 3; k++)
                    if (edge_no > s_st[k]) anchor[k] = edge_no;
            end
        end
        #1 checkOutput(tag);
    endtask

    task automatic assertArst();
        arst    = 1'b1;
        in_arst = 1'b1;
        #1 checkOutput("arst_async");
    endtask

    task automatic releaseArst();
        #2;
        arst    = 1'b0;
        in_arst = 1'b0;
        edge_no = 0;
        for (int k = 0; k < 3; k++) anchor[k] = s_st[k];
        #1 checkOutput("arst_release");
    endtask

    initial begin
        logic [31:0] rh;
        int          r;
        arst         = 1'b1;
        sw_rst_req   = 1'b0;
        ch_hold_v    = '0;
        in_arst      = 1'b1;
        edge_no      = 0;
        hold_at_edge = '0;
        compared     = 0;
        mismatched   = 0;
        for (int k = 0; k < 3; k++) anchor[k] = s_st[k];

        #2 checkOutput("reset_state");
        repeat (3) applyStimulus(1'b1, 32'h5, "in_arst");

        // Power-on sequence
        releaseArst();
        repeat (40) applyStimulus(1'b0, '0, "power_on");

        // Re-assert arst after channel 0 released, then a clean repeat
        assertArst();
        applyStimulus(1'b0, '0, "arst_held");
        releaseArst();
        repeat (7) applyStimulus(1'b0, '0, "pre_mid");
        assertArst();
        repeat (2) applyStimulus(1'b0, '0, "arst_held");
        releaseArst();
        repeat (40) applyStimulus(1'b0, '0, "repeat_seq");

        // Software request in DONE
        applyStimulus(1'b1, '0, "sw_done");
        repeat (40) applyStimulus(1'b0, '0, "sw_release");

        // Two requests during HOLD
        assertArst();
        applyStimulus(1'b0, '0, "arst_held");
        releaseArst();
        repeat (3) applyStimulus(1'b0, '0, "to_hold");
        applyStimulus(1'b1, '0, "sw_hold1");
        applyStimulus(1'b0, '0, "sw_gap");
        applyStimulus(1'b1, '0, "sw_hold2");
        repeat (40) applyStimulus(1'b0, '0, "sw_hold_rel");

        // Channel 1 forced throughout power-on, then cleared
        assertArst();
        applyStimulus(1'b0, 32'h2, "arst_held");
        releaseArst();
        repeat (40) applyStimulus(1'b0, 32'h2, "ch_hold_on");
        repeat (3) applyStimulus(1'b0, '0, "ch_hold_off");

        // Randomised requests, holds and arst pulses
        for (int n = 0; n < 400; n++) begin
            r  = $urandom_range(0, 99);
            rh = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom & $urandom) : 32'd0;
            if (r < 2) begin
                assertArst();
                applyStimulus(1'b0, rh, "rnd_arst");
                releaseArst();
            end else begin
                applyStimulus(r < 7, rh, "random");
            end
        end
        repeat (40) applyStimulus(1'b0, '0, "drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rst_seq_gen.md
RST_SEQ_GEN -- requirements
Module: rst_seq_gen

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high. The ports SHALL be named clk and arst.
REQ-002 param_num_ch, 4, number of reset output channels; legal range 1..32.
REQ-003 param_sync_stages, 2, synchroniser depth for arst deassertion; minimum 2.
REQ-004 param_hold_cycles, 16, clk cycles all channels stay asserted after synchronised release; minimum 1.
REQ-005 param_stagger_cycles, 4, clk cycles between release of channel i and channel i+1; minimum 1.
REQ-006 clk  input  1  free-running clock.
REQ-007 arst  input  1  asynchronous active-high reset.
REQ-008 sw_rst_req  input  1  synchronous software reset request, sampled on the clk rising edge.
REQ-009 ch_hold  input  param_num_ch  per-channel force-reset; synchronous, level-sensitive.
REQ-010 rst_out  output  param_num_ch  per-channel active-high reset; each bit comes straight from a flop.
REQ-011 busy  output  1  high while the release sequence is incomplete.
REQ-012 all_released  output  1  high when the state is DONE and every rst_out bit is 0.

Function
REQ-013 The FSM SHALL have the states ASSERT, SYNC, HOLD, RELEASE and DONE.
REQ-014 While arst=1: the state SHALL be ASSERT, all counters 0, and the synchroniser flops all 1.
REQ-015 On arst falling, the state SHALL move ASSERT->SYNC, and a 0 SHALL shift through the synchroniser, one stage per clk edge.
REQ-016 Numbering the first clk edge after arst falls as edge 1:
- the synchroniser output goes low after edge param_sync_stages;
- SYNC->HOLD on that edge, with the hold counter cleared.
REQ-017 HOLD SHALL count param_hold_cycles edges. rst_out[0] SHALL deassert on edge param_sync_stages+param_hold_cycles, and the state SHALL enter RELEASE on the same edge.
REQ-018 rst_out[i] SHALL deassert on edge param_sync_stages+param_hold_cycles+i*param_stagger_cycles. The release order SHALL be fixed, channel 0 first.
REQ-019 The state SHALL move RELEASE->DONE on the edge that releases channel param_num_ch-1.
- param_num_ch=1: HOLD->DONE directly.
REQ-020 The stagger counter SHALL wrap to 0 after each channel release. The channel index SHALL saturate at param_num_ch-1. Counter widths SHALL be sized by clog2 of the largest count, with no overflow at parameter maxima.
REQ-021 Effective rst_out[i] = sequencer_rst[i] OR ch_hold[i], registered.
- ch_hold[i] rising: rst_out[i]=1 on the next edge.
- ch_hold[i] falling in DONE: rst_out[i]=0 on the next edge.
- A held channel still consumes its stagger slot; it is not skipped.
REQ-022 sw_rst_req=1 on an edge in HOLD, RELEASE or DONE SHALL, on that edge:
- set all rst_out to 1;
- clear the hold counter, stagger counter and channel index;
- enter HOLD.
Channel 0 then releases param_hold_cycles edges later.
REQ-023 sw_rst_req SHALL be ignored in ASSERT and SYNC. A request held high for N edges SHALL restart the hold N times; the release begins after the last request.
REQ-024 A sw_rst_req during HOLD SHALL restart the count from 0.
REQ-025 busy SHALL equal (state != DONE). all_released SHALL be a combinational decode of registered state and rst_out, with no input-to-output path.

Reset
REQ-026 arst assertion in any state SHALL asynchronously force rst_out all-ones, busy=1, all_released=0 and state=ASSERT. This holds mid-sequence and mid-stagger.
REQ-027 No output SHALL deassert asynchronously. All releases SHALL occur on clk rising edges.

Verification
REQ-028 Power-on: param_num_ch=3, param_sync_stages=2, param_hold_cycles=4, param_stagger_cycles=3, arst released mid-cycle, ch_hold=0.
-> rst_out[0]=0 after edge 6, rst_out[1]=0 after edge 9, rst_out[2]=0 after edge 12.
-> busy falls and all_released rises after edge 12.
REQ-029 Same parameters, arst re-asserted between edges 7 and 8 (after ch0 release).
-> rst_out=3'b111 immediately, asynchronously.
-> On release, the full sequence repeats with identical edge counts.
REQ-030 In DONE, sw_rst_req=1 for 1 edge (edge k).
-> rst_out=3'b111 after edge k.
-> ch0 released after k+4, ch1 after k+7, ch2 after k+10.
REQ-031 sw_rst_req pulsed at HOLD edge 2, then again 2 edges later.
-> ch0 release occurs 4 edges after the second pulse.
REQ-032 ch_hold=3'b010 throughout power-on.
-> ch0 and ch2 release on edges 6 and 12; ch1 stays 1; all_released=0, busy=0.
-> Clearing ch_hold gives rst_out[1]=0 on the next edge, and all_released=1 on that same edge.
REQ-033 Parameter sweep with param_num_ch=1 and param_num_ch=32 at stagger 1.
-> no extra cycles, no index overflow, DONE reached on the last release edge.
